// File: rtl/alu_bist_sequencer.sv
// Built-in self-test sequencer for the 16-bit ALU: drives ADD/SUB/AND/OR/XOR vectors,
// checks result/zero/negative against a golden model and keeps first-failure diagnostics.
module alu_bist_sequencer #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned NUM_VECTORS = 32,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic             input_CLK,
  input  logic             input_Reset,
  input  logic             input_start,
  output logic [WIDTH-1:0] output_A,
  output logic [WIDTH-1:0] output_B,
  output logic [2:0]       output_ALUOp,
  input  logic [WIDTH-1:0] input_ALU,
  input  logic             input_Zero,
  input  logic             input_negative,
  output logic             output_busy,
  output logic             output_done,
  output logic             output_pass,
  output logic [7:0]       output_fail_count,
  output logic [2:0]       output_first_fail_op,
  output logic [6:0]       output_first_fail_idx
);

  localparam int unsigned IDX_W = 7;
  localparam int unsigned CNT_W = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
  localparam logic [2:0]  OP_ADD    = 3'b000;
  localparam logic [2:0]  OP_SUB    = 3'b001;
  localparam logic [2:0]  OP_AND    = 3'b100;
  localparam logic [2:0]  OP_OR     = 3'b101;
  localparam logic [2:0]  OP_XOR    = 3'b110;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] B_SCRAMBLE = 16'h5A5A;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [CNT_W-1:0]   fail_count_q, fail_count_d;
  logic [2:0]         ff_op_q, ff_op_d;
  logic [IDX_W-1:0]   ff_idx_q, ff_idx_d;

  logic [WIDTH-1:0]   gold_res;
  logic               gold_zero;
  logic               gold_neg;
  logic               mismatch;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_MASK : 16'h0000);
  endfunction

  function automatic logic [2:0] next_op(input logic [2:0] op);
    unique case (op)
      OP_ADD:  return OP_SUB;
      OP_SUB:  return OP_AND;
      OP_AND:  return OP_OR;
      OP_OR:   return OP_XOR;
      default: return OP_ADD;
    endcase
  endfunction

  // Golden model of the ALU response for the vector currently driven
  always_comb begin
    gold_res = '0;
    unique case (op_q)
      OP_ADD:  gold_res = a_q + b_q;
      OP_SUB:  gold_res = a_q - b_q;
      OP_AND:  gold_res = a_q & b_q;
      OP_OR:   gold_res = a_q | b_q;
      OP_XOR:  gold_res = a_q ^ b_q;
      default: gold_res = '0;
    endcase
    gold_zero = (gold_res == '0);
    gold_neg  = gold_res[WIDTH-1];
    mismatch  = (input_ALU != gold_res) || (input_Zero != gold_zero) ||
                (input_negative != gold_neg);
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    idx_d        = idx_q;
    lfsr_d       = lfsr_q;
    a_d          = a_q;
    b_d          = b_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_count_d = fail_count_q;
    ff_op_d      = ff_op_q;
    ff_idx_d     = ff_idx_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (input_start) begin
          state_d      = S_APPLY;
          lfsr_d       = SEED;
          fail_count_d = '0;
          ff_op_d      = '0;
          ff_idx_d     = '0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
          op_d         = OP_ADD;
          idx_d        = '0;
          a_d          = '0;
          b_d          = '0;
        end
      end
      S_APPLY: state_d = S_CHECK;
      S_CHECK: begin
        if (mismatch) begin
          if (fail_count_q != '1) fail_count_d = fail_count_q + CNT_W'(1);
          if (fail_count_q == '0) begin
            ff_op_d  = op_q;
            ff_idx_d = idx_q;
          end
        end
        // Only the random vectors consume LFSR states
        if (idx_q >= IDX_W'(2)) lfsr_d = lfsr_step(lfsr_q);
        if (idx_q < LAST_IDX) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_APPLY;
        end else if (op_q != OP_XOR) begin
          op_d    = next_op(op_q);
          idx_d   = '0;
          state_d = S_APPLY;
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_count_d == '0);
        end
        if (state_d == S_APPLY) begin
          if (idx_d == '0) begin
            a_d = '0;
            b_d = '0;
          end else if (idx_d == IDX_W'(1)) begin
            a_d = '1;
            b_d = WIDTH'(1);
          end else begin
            a_d = WIDTH'(lfsr_d);
            b_d = WIDTH'({lfsr_d[7:0], lfsr_d[15:8]} ^ B_SCRAMBLE);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge input_CLK or posedge input_Reset) begin
    if (input_Reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      idx_q        <= '0;
      lfsr_q       <= SEED;
      a_q          <= '0;
      b_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_count_q <= '0;
      ff_op_q      <= '0;
      ff_idx_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      lfsr_q       <= lfsr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_count_q <= fail_count_d;
      ff_op_q      <= ff_op_d;
      ff_idx_q     <= ff_idx_d;
    end
  end

  assign output_A              = a_q;
  assign output_B              = b_q;
  assign output_ALUOp          = op_q;
  assign output_busy           = busy_q;
  assign output_done           = done_q;
  assign output_pass           = pass_q;
  assign output_fail_count     = fail_count_q;
  assign output_first_fail_op  = ff_op_q;
  assign output_first_fail_idx = ff_idx_q;

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Bench for alu_bist_sequencer: a 32-vector instance against a behavioural ALU with
// selectable faults, and a 2-vector instance whose ALU computes A+B for SUB.
module tb_alu_bist_sequencer;

  localparam int unsigned N1     = 32;
  localparam int unsigned N2     = 2;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic clk = 1'b0;
  logic rst;
  logic start1, start2;
  int   fault_mode;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] a1, b1, alu1, a2, b2, alu2;
  logic [2:0]  op1, op2, ffop1, ffop2;
  logic [6:0]  ffidx1, ffidx2;
  logic [7:0]  fc1, fc2;
  logic        z1, n1, busy1, done1, pass1;
  logic        z2, n2, busy2, done2, pass2;

  always #5 clk = ~clk;

  function automatic logic [15:0] gold(input logic [2:0] op, input logic [15:0] a,
                                       input logic [15:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b100:  return a & b;
      3'b101:  return a | b;
      3'b110:  return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [2:0] op_at(input int o);
    case (o)
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b100;
      3:       return 3'b101;
      default: return 3'b110;
    endcase
  endfunction

  // Expected vector for an index; l_out is the LFSR state for the following vector
  function automatic void exp_vec(input int idx, input logic [15:0] l_in,
                                  output logic [15:0] l_out, output logic [15:0] a,
                                  output logic [15:0] b);
    l_out = l_in;
    if (idx == 0) begin
      a = 16'h0000; b = 16'h0000;
    end else if (idx == 1) begin
      a = 16'hFFFF; b = 16'h0001;
    end else begin
      a = l_in;
      b = {l_in[7:0], l_in[15:8]} ^ 16'h5A5A;
      l_out = l_in[0] ? ((l_in >> 1) ^ 16'hB400) : (l_in >> 1);
    end
  endfunction

  function automatic int zero_count(input int n);
    logic [15:0] l, nl, a, b;
    int c;
    l = SEED;
    c = 0;
    for (int o = 0; o < 5; o++) begin
      for (int i = 0; i < n; i++) begin
        exp_vec(i, l, nl, a, b);
        l = nl;
        if (gold(op_at(o), a, b) == 16'h0000) c++;
      end
    end
    return c;
  endfunction

  // Behavioural ALUs (mode 1: zero flag stuck at 0)
  always_comb begin
    alu1 = gold(op1, a1, b1);
    z1   = (fault_mode == 1) ? 1'b0 : (alu1 == 16'h0000);
    n1   = alu1[15];
  end

  always_comb begin
    alu2 = (op2 == 3'b001) ? (a2 + b2) : gold(op2, a2, b2);
    z2   = (alu2 == 16'h0000);
    n2   = alu2[15];
  end

  alu_bist_sequencer #(.WIDTH(16), .NUM_VECTORS(N1), .SEED(SEED)) dut1 (
    .input_CLK(clk), .input_Reset(rst), .input_start(start1),
    .output_A(a1), .output_B(b1), .output_ALUOp(op1),
    .input_ALU(alu1), .input_Zero(z1), .input_negative(n1),
    .output_busy(busy1), .output_done(done1), .output_pass(pass1),
    .output_fail_count(fc1), .output_first_fail_op(ffop1), .output_first_fail_idx(ffidx1)
  );

  alu_bist_sequencer #(.WIDTH(16), .NUM_VECTORS(N2), .SEED(SEED)) dut2 (
    .input_CLK(clk), .input_Reset(rst), .input_start(start2),
    .output_A(a2), .output_B(b2), .output_ALUOp(op2),
    .input_ALU(alu2), .input_Zero(z2), .input_negative(n2),
    .output_busy(busy2), .output_done(done2), .output_pass(pass2),
    .output_fail_count(fc2), .output_first_fail_op(ffop2), .output_first_fail_idx(ffidx2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Full run on dut1, checking every driven vector cycle by cycle
  task automatic run1(input int restart_at);
    logic [15:0] l, nl, ea, eb;
    int verr, e;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    check("start_busy", 64'(busy1), 64'(1));
    check("start_clear", 64'({done1, pass1, fc1}), 64'(0));
    check("start_vec", 64'({op1, a1, b1}), 64'(0));
    l = SEED;
    verr = 0;
    e = 1;
    for (int o = 0; o < 5; o++) begin
      for (int i = 0; i < int'(N1); i++) begin
        exp_vec(i, l, nl, ea, eb);
        l = nl;
        if ({a1, b1, op1, busy1, done1} !== {ea, eb, op_at(o), 1'b1, 1'b0}) verr++;
        start1 = (e == restart_at);
        @(posedge clk); #1; start1 = 1'b0; e++;
        if ({busy1, done1} !== 2'b10) verr++;
        start1 = (e == restart_at);
        @(posedge clk); #1; start1 = 1'b0; e++;
      end
    end
    check("vectors", 64'(verr), 64'(0));
    check("done_at_320", 64'({busy1, done1}), 64'(2'b01));
  endtask

  typedef struct {
    int         mode;
    int         restart_at;
    logic       exp_pass;
    logic [7:0] exp_fc;
    logic [2:0] exp_op;
    logic [6:0] exp_idx;
  } rec_t;

  rec_t tbl[3];
  int   cnt;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{mode: 1, restart_at: 0, exp_pass: 1'b0, exp_fc: 8'(zero_count(N1)),
               exp_op: 3'b000, exp_idx: 7'd0};
    tbl[1] = '{mode: 0, restart_at: 10, exp_pass: 1'b1, exp_fc: 8'd0,
               exp_op: 3'b000, exp_idx: 7'd0};
    tbl[2] = '{mode: 0, restart_at: 0, exp_pass: 1'b1, exp_fc: 8'd0,
               exp_op: 3'b000, exp_idx: 7'd0};

    rst = 1'b0; start1 = 1'b0; start2 = 1'b0; fault_mode = 0;
    #2 rst = 1'b1;
    #1;
    check("reset1", 64'({a1, b1, op1, busy1, done1, pass1, fc1, ffop1, ffidx1}), 64'(0));
    check("reset2", 64'({a2, b2, op2, busy2, done2, pass2, fc2, ffop2, ffidx2}), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Two-vector instance with SUB faulted to ADD
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    cnt = 0;
    while (!done2 && cnt < 100) begin
      @(posedge clk); #1; cnt++;
    end
    check("n2_latency", 64'(cnt), 64'(20));
    check("n2_fail_count", 64'(fc2), 64'(1));
    check("n2_first_op", 64'(ffop2), 64'(3'b001));
    check("n2_first_idx", 64'(ffidx2), 64'(1));
    check("n2_pass", 64'({busy2, pass2}), 64'(0));

    for (int k = 0; k < 3; k++) begin
      fault_mode = tbl[k].mode;
      run1(tbl[k].restart_at);
      check("pass", 64'(pass1), 64'(tbl[k].exp_pass));
      check("fail_count", 64'(fc1), 64'(tbl[k].exp_fc));
      check("first_op", 64'(ffop1), 64'(tbl[k].exp_op));
      check("first_idx", 64'(ffidx1), 64'(tbl[k].exp_idx));
      repeat (3) @(posedge clk);
      #1;
      check("done_hold", 64'({busy1, done1, pass1, fc1}),
            64'({1'b0, 1'b1, tbl[k].exp_pass, tbl[k].exp_fc}));
    end

    // Asynchronous abort mid-run, then a clean rerun from the same seed
    fault_mode = 0;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (49) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_clear", 64'({a1, b1, op1, busy1, done1, pass1, fc1, ffop1, ffidx1}), 64'(0));
    @(negedge clk); rst = 1'b0;
    run1(0);
    check("rerun_pass", 64'({pass1, fc1}), 64'({1'b1, 8'd0}));

    // Start coinciding with reset: reset wins
    @(negedge clk); rst = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    check("start_vs_reset", 64'({busy1, done1, pass1}), 64'(0));
    @(negedge clk); rst = 1'b0; start1 = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", 64'({busy1, done1}), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_bist_sequencer.md
Name: alu_bist_sequencer

Overview:
Built-in self-test initiator for the 16-bit ALU. It drives operand/opcode stimulus into the ALU's input side and checks the ALU's result, zero and negative outputs against an internal golden model. The sequence covers ADD, SUB, AND, OR and XOR. It sits beside the ALU in the multi-cycle datapath, muxed onto the ALU inputs by the test controller, and reports pass/fail and first-failure diagnostics.

Parameters:
WIDTH, 16, operand/result width (only 16 supported).
NUM_VECTORS, 32, vectors per opcode (min 2, max 128).
SEED, 16'hACE1, LFSR reseed value on every start (nonzero).

Ports:
input_CLK  in  1  clock, rising edge.
input_Reset  in  1  asynchronous, active-high reset.
input_start  in  1  pulse; begins a run when idle.
output_A  out  16  ALU operand A.
output_B  out  16  ALU operand B.
output_ALUOp  out  3  ALU opcode.
input_ALU  in  16  ALU result (combinational from output_A/B/ALUOp).
input_Zero  in  1  ALU zero flag.
input_negative  in  1  ALU negative flag.
output_busy  out  1  run in progress.
output_done  out  1  run complete; held until next accepted start.
output_pass  out  1  done and zero failures.
output_fail_count  out  8  mismatching vectors, saturates at 255.
output_first_fail_op  out  3  opcode of first mismatch.
output_first_fail_idx  out  7  vector index of first mismatch.

Behaviour:
- Reset (async, active-high) clears every output to 0 and the state to IDLE. A reset mid-run aborts immediately, with no done and no pass.
- FSM states: IDLE, APPLY, CHECK, DONE. All outputs are registered.
- IDLE/DONE + start=1 at an edge:
  - reseed the LFSR to SEED;
  - clear the fail count and first-fail registers;
  - clear done/pass;
  - set busy=1, op=000, idx=0;
  - go to APPLY with vector 0 driven.
- Start while busy is ignored.
- APPLY (1 cycle): outputs hold; the ALU settles. Next edge goes to CHECK.
- CHECK (1 cycle): at the closing edge, compare all three ALU outputs against the golden model (see below) and count any mismatch.
  - If idx < NUM_VECTORS-1: idx++ and go to APPLY.
  - Else, if op is not the last: advance op, set idx=0 and go to APPLY.
  - Else: go to DONE.
- Op order: 000 ADD, 001 SUB, 100 AND, 101 OR, 110 XOR. The others are never issued.
- Vector generation:
  - idx 0: A=16'h0000, B=16'h0000.
  - idx 1: A=16'hFFFF, B=16'h0001.
  - idx ≥2: A=lfsr, B={lfsr[7:0],lfsr[15:8]}^16'h5A5A. The LFSR advances once per random vector, when leaving CHECK.
  - LFSR: 16-bit Galois, mask 16'hB400, shift right.
- Golden model:
  - result is modulo 2^16: A+B, A−B, A&B, A|B, A^B;
  - zero = (result==0);
  - negative = result[15].
- First-fail registers:
  - capture op/idx on the first mismatch only;
  - hold afterwards;
  - read 0 if no failure.
- Fail count saturation: the count holds at 255; further mismatches do not wrap it.
- Timing: total run = 2·5·NUM_VECTORS cycles.
  - busy=1 from the edge after start until the final CHECK edge.
  - At that edge: busy=0, done=1, pass=(fail_count==0).
- DONE: outputs A/B/ALUOp hold their last values. done/pass/diagnostics hold until reset or the next start.
- Simultaneous start and reset: reset wins.

Test Plan:
- Correct ALU model, NUM_VECTORS=32, start pulse:
  - busy high for 320 cycles;
  - done=1 and pass=1 exactly 320 edges after the start edge;
  - fail_count=0;
  - first_fail_op=0, first_fail_idx=0.
- ALU model with input_Zero stuck 0, NUM_VECTORS=32:
  - pass=0;
  - fail_count=6 (idx0 for all 5 ops, plus ADD idx1: FFFF+0001=0);
  - first_fail_op=000, first_fail_idx=0.
- NUM_VECTORS=2, ALU SUB faulted to compute A+B:
  - done after 20 cycles;
  - fail_count=1;
  - first_fail_op=001, first_fail_idx=1 (expected FFFE, flags Z=0 N=1).
- Reset asserted asynchronously at cycle 50 of a run:
  - all outputs 0 immediately, state IDLE;
  - a new start gives the full 320-cycle run with the identical LFSR sequence.
- Second start pulse at cycle 10 of a run:
  - ignored, and done still arrives at edge 320.
- After DONE, a new start:
  - clears done/pass/fail_count on that edge;
  - busy=1;
  - output_ALUOp=000, output_A=0, output_B=0.
